// File: rtl/cpu_dsp_port_bridge_if.sv
// CPU port bus plus display write port seen by cpu_dsp_port_bridge.
// master = CPU/display side, slave = the bridge.
interface cpu_dsp_port_bridge_if;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  in_port;
    logic [4:0]  dsp_row;
    logic [6:0]  dsp_col;
    logic        dsp_en;
    logic        dsp_wr;
    logic [15:0] dsp_wr_data;

    modport master (
        output port_id, out_port, write_strobe, read_strobe,
        input  in_port, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe,
        output in_port, dsp_row, dsp_col, dsp_en, dsp_wr, dsp_wr_data
    );
endinterface

// File: rtl/cpu_dsp_port_bridge.sv
// kcpsm3 port-I/O slave driving the character display write port: cursor/attr
// registers, CHAR writes, hardware clear. Option: CPU_DSP_BRIDGE_AUTOINC_EN.
module cpu_dsp_port_bridge #(
    parameter logic [7:0]  BASE_PORT = 8'h00,
    parameter int unsigned NUM_ROWS  = 30,
    parameter int unsigned NUM_COLS  = 80
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_dsp_port_bridge_if.slave  bus
);

    localparam logic [7:0] ADDR_ROW  = BASE_PORT;
    localparam logic [7:0] ADDR_COL  = 8'(BASE_PORT + 8'd1);
    localparam logic [7:0] ADDR_ATTR = 8'(BASE_PORT + 8'd2);
    localparam logic [7:0] ADDR_CHAR = 8'(BASE_PORT + 8'd3);
    localparam logic [7:0] ADDR_CTRL = 8'(BASE_PORT + 8'd4);
    localparam logic [4:0] ROW_LAST  = 5'(NUM_ROWS - 1);
    localparam logic [6:0] COL_LAST  = 7'(NUM_COLS - 1);
    localparam logic [7:0] BLANK     = 8'h20;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q, state_d;
    logic [4:0]  row_q, clr_row_q, clr_row_n;
    logic [6:0]  col_q, clr_col_q, clr_col_n;
    logic [7:0]  attr_q, clr_attr_q;
    logic        busy_q, overflow_q;
    logic [7:0]  in_port_q;
    logic [4:0]  dsp_row_q;
    logic [6:0]  dsp_col_q;
    logic        dsp_en_q, dsp_wr_q;
    logic [15:0] dsp_wr_data_q;

    logic        wr_row, wr_col, wr_attr, wr_char, wr_ctrl, rd_status;
    logic        start_clr, clr_step, clr_done, char_ok, char_drop, last_cell;
    logic [7:0]  rd_data;

    assign wr_row    = bus.write_strobe && (bus.port_id == ADDR_ROW);
    assign wr_col    = bus.write_strobe && (bus.port_id == ADDR_COL);
    assign wr_attr   = bus.write_strobe && (bus.port_id == ADDR_ATTR);
    assign wr_char   = bus.write_strobe && (bus.port_id == ADDR_CHAR);
    assign wr_ctrl   = bus.write_strobe && (bus.port_id == ADDR_CTRL);
    assign rd_status = bus.read_strobe  && (bus.port_id == ADDR_CTRL);

    // clr_row/clr_col track the cell being written in the current cycle
    assign last_cell = (clr_row_q == ROW_LAST) && (clr_col_q == COL_LAST);
    assign clr_col_n = (clr_col_q == COL_LAST) ? 7'd0 : clr_col_q + 7'd1;
    assign clr_row_n = (clr_col_q == COL_LAST) ? clr_row_q + 5'd1 : clr_row_q;

    // Read data is decoded every cycle from port_id alone
    always_comb begin
        rd_data = 8'h00;
        case (bus.port_id)
            ADDR_ROW:  rd_data = {3'b000, row_q};
            ADDR_COL:  rd_data = {1'b0, col_q};
            ADDR_ATTR: rd_data = attr_q;
            ADDR_CTRL: rd_data = {6'b000000, overflow_q, busy_q};
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        start_clr = 1'b0;
        clr_step  = 1'b0;
        clr_done  = 1'b0;
        char_ok   = 1'b0;
        char_drop = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_ctrl && bus.out_port[0]) begin
                    state_d   = CLEAR;
                    start_clr = 1'b1;
                end else if (wr_char) begin
                    char_ok = 1'b1;
                end
            end
            CLEAR: begin
                char_drop = wr_char;
                if (last_cell) begin
                    state_d  = IDLE;
                    clr_done = 1'b1;
                end else begin
                    clr_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q         <= 5'd0;
            col_q         <= 7'd0;
            attr_q        <= 8'h07;
            clr_row_q     <= 5'd0;
            clr_col_q     <= 7'd0;
            clr_attr_q    <= 8'h00;
            busy_q        <= 1'b0;
            overflow_q    <= 1'b0;
            in_port_q     <= 8'h00;
            dsp_row_q     <= 5'd0;
            dsp_col_q     <= 7'd0;
            dsp_en_q      <= 1'b0;
            dsp_wr_q      <= 1'b0;
            dsp_wr_data_q <= 16'h0000;
        end else begin
            in_port_q <= rd_data;
            dsp_en_q  <= 1'b0;
            dsp_wr_q  <= 1'b0;

            if (wr_row)  row_q  <= (32'(bus.out_port) < NUM_ROWS) ? 5'(bus.out_port) : 5'd0;
            if (wr_col)  col_q  <= (32'(bus.out_port) < NUM_COLS) ? 7'(bus.out_port) : 7'd0;
            if (wr_attr) attr_q <= bus.out_port;

            if (start_clr) begin
                row_q         <= 5'd0;
                col_q         <= 7'd0;
                clr_attr_q    <= attr_q;
                clr_row_q     <= 5'd0;
                clr_col_q     <= 7'd0;
                busy_q        <= 1'b1;
                dsp_en_q      <= 1'b1;
                dsp_wr_q      <= 1'b1;
                dsp_row_q     <= 5'd0;
                dsp_col_q     <= 7'd0;
                dsp_wr_data_q <= {attr_q, BLANK};
            end

            if (clr_step) begin
                clr_row_q     <= clr_row_n;
                clr_col_q     <= clr_col_n;
                dsp_en_q      <= 1'b1;
                dsp_wr_q      <= 1'b1;
                dsp_row_q     <= clr_row_n;
                dsp_col_q     <= clr_col_n;
                dsp_wr_data_q <= {clr_attr_q, BLANK};
            end

            if (clr_done) busy_q <= 1'b0;

            if (char_ok) begin
                dsp_en_q      <= 1'b1;
                dsp_wr_q      <= 1'b1;
                dsp_row_q     <= row_q;
                dsp_col_q     <= col_q;
                dsp_wr_data_q <= {attr_q, bus.out_port};
`ifdef CPU_DSP_BRIDGE_AUTOINC_EN
                if (col_q == COL_LAST) begin
                    col_q <= 7'd0;
                    row_q <= (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
                end else begin
                    col_q <= col_q + 7'd1;
                end
`else
                // cursor stays put; only ROW/COL writes and CLEAR move it
`endif
            end

            // overflow set and STATUS read never coincide: one strobe per cycle
            if (char_drop)      overflow_q <= 1'b1;
            else if (rd_status) overflow_q <= 1'b0;
        end
    end

    assign bus.in_port     = in_port_q;
    assign bus.dsp_row     = dsp_row_q;
    assign bus.dsp_col     = dsp_col_q;
    assign bus.dsp_en      = dsp_en_q;
    assign bus.dsp_wr      = dsp_wr_q;
    assign bus.dsp_wr_data = dsp_wr_data_q;

endmodule

// File: doc/cpu_dsp_port_bridge.md
Name: cpu_dsp_port_bridge

Overview:
Port-I/O slave that connects the kcpsm3 CPU's port bus to the character display's write interface. It holds the cursor (row/col) and attribute registers, turns CPU character writes into single-cycle display writes with cursor auto-advance, and runs a hardware clear-screen sequencer. It sits between the CPU port signals and the dsp write port in the display top level.

Parameters:
BASE_PORT, 8'h00, port_id of register offset 0; the block decodes BASE_PORT..BASE_PORT+4.
NUM_ROWS, 30, visible text rows; legal row values 0..NUM_ROWS-1 (max 32).
NUM_COLS, 80, visible text columns; legal col values 0..NUM_COLS-1 (max 128).

Ports:
clk  in  1  system clock, all logic on the rising edge
reset  in  1  synchronous, active-low reset
port_id  in  8  CPU port address
out_port  in  8  CPU write data
write_strobe  in  1  CPU write qualifier, one cycle
read_strobe  in  1  CPU read qualifier, one cycle
in_port  out  8  CPU read data, registered
dsp_row  out  5  display row of the current write
dsp_col  out  7  display column of the current write
dsp_en  out  1  display access enable, one-cycle pulse
dsp_wr  out  1  display write enable, asserted together with dsp_en
dsp_wr_data  out  16  {attribute[7:0], character[7:0]}

Behaviour:
- Reset (reset==0 at an edge): all outputs 0; cursor row/col = 0; attr = 8'h07; busy = 0; overflow = 0; FSM = IDLE. Reset during CLEAR aborts it immediately, with no further display writes.
- Register map (offset from BASE_PORT):
  - +0 ROW: write sets row; value >= NUM_ROWS sets row to 0. Reads return the row.
  - +1 COL: write sets col; value >= NUM_COLS sets col to 0. Reads return the col.
  - +2 ATTR: read/write, 8 bits.
  - +3 CHAR: write only; reads return 0.
  - +4 CTRL/STATUS: write bit0=1 starts CLEAR. Read returns {6'b0, overflow, busy}.
- Other port_ids are ignored on write and read 0.
- Read path: in_port registered every cycle from the port_id decode, so there is 1 cycle of latency. port_id is stable for 2 cycles before read_strobe. A STATUS read (read_strobe with port_id==BASE+4) clears overflow at that edge.
- CHAR write in IDLE, captured at edge N, produces the following during cycle N+1:
  - dsp_en=dsp_wr=1
  - dsp_row/dsp_col = cursor before the advance
  - dsp_wr_data = {attr, out_port}
- Cursor advance happens at edge N:
  - col+1;
  - if col==NUM_COLS-1 then col=0 and row+1;
  - if row==NUM_ROWS-1 as well, then row=0.
- dsp_en/dsp_wr deassert in cycle N+2 unless another write occurs.
- FSM states IDLE and CLEAR.
  - IDLE->CLEAR on a CTRL write with bit0=1. At that edge: busy=1, cursor=(0,0), clear attribute latched from attr.
  - CLEAR writes one cell per cycle in row-major order, (0,0) through (NUM_ROWS-1,NUM_COLS-1), with data {latched_attr, 8'h20}.
  - The first write occurs in the cycle after the command; there are NUM_ROWS*NUM_COLS consecutive write cycles.
  - CLEAR->IDLE at the edge ending the last write cycle; busy=0 from the next cycle.
- During CLEAR:
  - A CHAR write is dropped and sets overflow (sticky).
  - A CTRL write is ignored.
  - ROW/COL/ATTR writes update the registers and do not disturb the sequence, which uses its own counters.
- The CPU issues at most one strobe per cycle, so no CPU-vs-CPU conflict exists.

Optional Feature:
Macro CPU_DSP_BRIDGE_AUTOINC_EN.
- Defined: cursor auto-advance and wrap after each CHAR write, as described above.
- Undefined: the cursor is unchanged by CHAR writes; only ROW/COL writes and CLEAR move it. CLEAR sequencing is unaffected.

Test Plan:
1. Reset, then read +0/+1/+2/+4 -> in_port 0, 0, 8'h07, 0; all dsp_* outputs 0 throughout reset.
2. Write ROW=5, COL=10, ATTR=8'h1E, CHAR=8'h41 -> one cycle with dsp_en=dsp_wr=1, dsp_row=5, dsp_col=10, dsp_wr_data=16'h1E41; COL then reads 11.
3. Write ROW=29, COL=79, CHAR=8'h42 -> write lands at (29,79); row/col then read 0/0. Write COL=200 -> COL reads 0.
4. ATTR=8'h70, CTRL=1 -> busy=1; exactly 2400 consecutive write pulses, first at (0,0) and last at (29,79), all data 16'h7020; busy=0 afterwards.
5. During CLEAR, write CHAR=8'h43 -> no extra pulse; STATUS reads 8'h03, then a second read returns 8'h01 (while busy) or 8'h00 (after).
6. Assert reset 100 cycles into CLEAR -> dsp_en=0 from the next cycle; busy=0; no further writes after reset is released.
